// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with runtime divider/mode, one-hot chip
// selects and chip-select hold across multi-word bursts.
// Ports: clk, rst_n (async, active-low); start + data_in/cs_sel/cpol/cpha/
// div/hold_cs request one word; cs_release ends a held burst; miso in;
// sck/mosi/cs_n drive the bus; data_out/new_data return the received
// word; busy is high while a word is in flight.
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    localparam int CS_W  = $clog2(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  div,
    input  logic              hold_cs,
    input  logic              cs_release,
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic [DATA_W-1:0] data_out,
    output logic              new_data,
    output logic              busy
);
    localparam int EW   = $clog2(2 * DATA_W) + 1;
    localparam int CSW1 = CS_W + 1;

    localparam logic [EW-1:0]     LAST_M1 = EW'(2 * DATA_W - 1);
    localparam logic [CS_W:0]     NCS     = CSW1'(NUM_CS);
    localparam logic [NUM_CS-1:0] CS_ONE  = NUM_CS'(1);
    localparam logic [NUM_CS-1:0] CS_OFF  = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_TAIL  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_DESEL = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [EW-1:0]     ecnt_q, ecnt_d;
    logic [CS_W-1:0]   sel_q, sel_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              hold_q, hold_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              nd_q, nd_d;
    logic              busy_q, busy_d;
    logic              sel_ok, accept, hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ecnt_d  = ecnt_q;
        sel_d   = sel_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        div_d   = div_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        dout_d  = dout_q;
        nd_d    = 1'b0;
        busy_d  = busy_q;
        cnt_inc = cnt_q + DIV_W'(1);
        hit     = (cnt_q == div_q);
        sel_ok  = ({1'b0, cs_sel} < NCS);
        accept  = start && sel_ok &&
                  (state_q == S_IDLE || state_q == S_HOLD);

        if (accept) begin
            sel_d  = cs_sel;
            cpol_d = cpol;
            cpha_d = cpha;
            div_d  = div;
            hold_d = hold_cs;
            busy_d = 1'b1;
            cnt_d  = '0;
            ecnt_d = '0;
            rx_d   = '0;
            sck_d  = cpol;
            pend_d = 1'b0;
            // cpha=0 presents the MSB during SETUP; cpha=1 shifts it
            // out on the first edge.
            tx_d   = cpha ? data_in : {data_in[DATA_W-2:0], 1'b0};
            mosi_d = cpha ? 1'b0 : data_in[DATA_W-1];
            if (state_q == S_HOLD && cs_sel != sel_q) begin
                state_d = S_DESEL;
                pend_d  = 1'b1;
                cs_n_d  = CS_OFF;
            end else begin
                state_d = S_SETUP;
                cs_n_d  = ~(CS_ONE << cs_sel);
            end
        end else begin
            case (state_q)
                S_IDLE: ;
                S_HOLD: begin
                    if (cs_release) begin
                        state_d = S_DESEL;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                        cs_n_d  = CS_OFF;
                    end
                end
                S_SETUP, S_XFER: begin
                    if (hit) begin
                        cnt_d  = '0;
                        sck_d  = ~sck_q;
                        ecnt_d = ecnt_q + EW'(1);
                        // Even count = leading edge; sample on leading
                        // when cpha=0, on trailing when cpha=1.
                        if (ecnt_q[0] == cpha_q) begin
                            rx_d = {rx_q[DATA_W-2:0], miso};
                        end else begin
                            mosi_d = tx_q[DATA_W-1];
                            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                        end
                        if (state_q == S_SETUP) begin
                            state_d = S_XFER;
                        end else if (ecnt_q == LAST_M1) begin
                            state_d = S_TAIL;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_TAIL: begin
                    if (hit) begin
                        cnt_d  = '0;
                        dout_d = rx_q;
                        nd_d   = 1'b1;
                        busy_d = 1'b0;
                        if (hold_q) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_IDLE;
                            cs_n_d  = CS_OFF;
                            mosi_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_DESEL: begin
                    if (hit) begin
                        cnt_d = '0;
                        if (pend_q) begin
                            state_d = S_SETUP;
                            pend_d  = 1'b0;
                            cs_n_d  = ~(CS_ONE << sel_q);
                        end else begin
                            state_d = S_IDLE;
                            mosi_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cs_n_d  = CS_OFF;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ecnt_q  <= '0;
            sel_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            div_q   <= '0;
            hold_q  <= 1'b0;
            pend_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= CS_OFF;
            dout_q  <= '0;
            nd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ecnt_q  <= ecnt_d;
            sel_q   <= sel_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            dout_q  <= dout_d;
            nd_q    <= nd_d;
            busy_q  <= busy_d;
        end
    end

    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign data_out = dout_q;
    assign new_data = nd_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: vector table plus hand sequences for the SPI
// master; received words are checked through an expected-result queue.
module tb_spi_master_multi;

    logic clk;
    logic rst_n;
    int   cyc;

    // 8-bit, 4-CS instance
    logic       a_start, a_cpol, a_cpha, a_hold, a_cs_release, a_miso;
    logic [7:0] a_data_in, a_div, a_data_out;
    logic [1:0] a_cs_sel;
    logic       a_sck, a_mosi, a_new_data, a_busy;
    logic [3:0] a_cs_n;
    logic       a_loop, a_mconst;

    // 16-bit, 3-CS instance
    logic        b_start, b_cpol, b_cpha, b_hold, b_cs_release, b_miso;
    logic [15:0] b_data_in, b_data_out;
    logic [7:0]  b_div;
    logic [1:0]  b_cs_sel;
    logic        b_sck, b_mosi, b_new_data, b_busy;
    logic [2:0]  b_cs_n;

    assign a_miso = a_loop ? a_mosi : a_mconst;
    assign b_miso = b_mosi;

    spi_master_multi #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(a_start), .data_in(a_data_in),
        .cs_sel(a_cs_sel), .cpol(a_cpol), .cpha(a_cpha), .div(a_div),
        .hold_cs(a_hold), .cs_release(a_cs_release), .miso(a_miso),
        .sck(a_sck), .mosi(a_mosi), .cs_n(a_cs_n),
        .data_out(a_data_out), .new_data(a_new_data), .busy(a_busy)
    );

    spi_master_multi #(.DATA_W(16), .NUM_CS(3), .DIV_W(8)) u16 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .data_in(b_data_in),
        .cs_sel(b_cs_sel), .cpol(b_cpol), .cpha(b_cpha), .div(b_div),
        .hold_cs(b_hold), .cs_release(b_cs_release), .miso(b_miso),
        .sck(b_sck), .mosi(b_mosi), .cs_n(b_cs_n),
        .data_out(b_data_out), .new_data(b_new_data), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic [1:0] sel;
        logic       pol;
        logic       pha;
        logic [7:0] dv;
        logic       loop;
        logic       mc;
        logic       poke;
        logic [7:0] exp;
        logic [3:0] csn;
    } vec_t;

    typedef struct {
        logic        which;
        logic [15:0] data;
        int          due;
    } sb_t;

    vec_t vt[6];
    sb_t  sbq[$];
    int   n_chk;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic which, input logic [15:0] d,
                        input int due);
        sb_t s;
        s.which = which;
        s.data  = d;
        s.due   = due;
        sbq.push_back(s);
    endtask

    // Called at the negedge where a new_data pulse is visible.
    task automatic check_nd();
        sb_t s;
        logic [15:0] act;
        if (sbq.size() == 0) begin
            chk("nd_unexpected", 32'd1, 32'd0);
        end else begin
            s = sbq.pop_front();
            chk("nd_unit", {31'd0, b_new_data}, {31'd0, s.which});
            act = s.which ? b_data_out : {8'h00, a_data_out};
            chk("nd_data", {16'd0, act}, {16'd0, s.data});
            chk("nd_time", cyc, s.due);
        end
    endtask

    task automatic wait_nd(input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (a_new_data || b_new_data) seen = 1'b1;
        end
        chk("nd_seen", {31'd0, seen}, 32'd1);
        if (seen) check_nd();
        else if (sbq.size() != 0) void'(sbq.pop_front());
    endtask

    task automatic quiet(input int n);
        int cnt;
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (a_new_data || b_new_data) cnt++;
        end
        chk("no_nd", cnt, 0);
    endtask

    // Starts at a negedge; drives one word on u8 and models the sck
    // waveform, chip select and busy cycle by cycle until new_data.
    task automatic xfer8(input vec_t v, input logic hold);
        int   t0, lat, h, o, e, errs;
        logic done, exp_sck;
        h    = int'(v.dv) + 1;
        lat  = 1 + 17 * h;
        errs = 0;
        done = 1'b0;
        a_data_in = v.d;
        a_cs_sel  = v.sel;
        a_cpol    = v.pol;
        a_cpha    = v.pha;
        a_div     = v.dv;
        a_hold    = hold;
        a_loop    = v.loop;
        a_mconst  = v.mc;
        a_start   = 1'b1;
        t0 = cyc;
        push(1'b0, {8'h00, v.exp}, t0 + lat);
        for (int i = 0; i < lat + 8 && !done; i++) begin
            @(negedge clk);
            o = cyc - t0;
            if (v.poke && o == 3) begin
                a_start   = 1'b1;
                a_cs_sel  = v.sel + 2'd1;
                a_data_in = ~v.d;
            end else begin
                a_start = 1'b0;
            end
            e = (o - 1) / h;
            if (e > 16) e = 16;
            exp_sck = v.pol ^ e[0];
            if (a_sck !== exp_sck) errs++;
            if (o < lat) begin
                if (a_cs_n !== v.csn) errs++;
                if (a_busy !== 1'b1) errs++;
            end else begin
                if (a_cs_n !== (hold ? v.csn : 4'hF)) errs++;
                if (a_busy !== 1'b0) errs++;
            end
            if (a_new_data) done = 1'b1;
        end
        chk("wave", errs, 0);
        chk("nd_seen", {31'd0, done}, 32'd1);
        if (done) check_nd();
        else if (sbq.size() != 0) void'(sbq.pop_front());
    endtask

    initial begin
        vec_t w;
        int   c0, n, t0;
        logic prev;

        vt[0] = '{8'hA5, 2'd1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0,
                  8'hA5, 4'b1101};
        vt[1] = '{8'h00, 2'd0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0,
                  8'hFF, 4'b1110};
        vt[2] = '{8'h3C, 2'd2, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b1,
                  8'h3C, 4'b1011};
        vt[3] = '{8'h5A, 2'd3, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0,
                  8'h00, 4'b0111};
        vt[4] = '{8'h81, 2'd0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0,
                  8'h81, 4'b1110};
        vt[5] = '{8'h7E, 2'd1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0,
                  8'h7E, 4'b1101};

        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        a_start = 1'b0; a_cpol = 1'b0; a_cpha = 1'b0; a_hold = 1'b0;
        a_cs_release = 1'b0; a_data_in = '0; a_div = '0; a_cs_sel = '0;
        a_loop = 1'b1; a_mconst = 1'b0;
        b_start = 1'b0; b_cpol = 1'b0; b_cpha = 1'b0; b_hold = 1'b0;
        b_cs_release = 1'b0; b_data_in = '0; b_div = '0; b_cs_sel = '0;

        repeat (3) @(negedge clk);
        chk("rst_csn", {28'd0, a_cs_n}, 32'hF);
        chk("rst_sck", {31'd0, a_sck}, 32'd0);
        chk("rst_mosi", {31'd0, a_mosi}, 32'd0);
        chk("rst_dout", {24'd0, a_data_out}, 32'd0);
        chk("rst_nd", {31'd0, a_new_data}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: each word starts in the new_data cycle of the previous.
        for (int i = 0; i < 6; i++) xfer8(vt[i], 1'b0);

        // Same-CS burst with chip select held between words.
        w = '{8'h12, 2'd2, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0,
              8'h12, 4'b1011};
        xfer8(w, 1'b1);
        @(negedge clk);
        chk("hold_csn", {28'd0, a_cs_n}, 32'hB);
        chk("hold_busy", {31'd0, a_busy}, 32'd0);
        w.d = 8'h34;
        w.exp = 8'h34;
        xfer8(w, 1'b0);

        // HOLD on cs0, then a start on cs3 forces a deselect gap.
        w = '{8'h99, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0,
              8'h99, 4'b1110};
        xfer8(w, 1'b1);
        a_data_in = 8'h66; a_cs_sel = 2'd3; a_div = 8'd1;
        a_hold = 1'b0; a_start = 1'b1;
        c0 = cyc;
        push(1'b0, 16'h0066, c0 + 37);
        @(negedge clk);
        a_start = 1'b0;
        chk("desel_csn1", {28'd0, a_cs_n}, 32'hF);
        chk("desel_busy", {31'd0, a_busy}, 32'd1);
        @(negedge clk);
        chk("desel_csn2", {28'd0, a_cs_n}, 32'hF);
        @(negedge clk);
        chk("desel_newcs", {28'd0, a_cs_n}, 32'h7);
        wait_nd(100);

        // Release a held burst without another word.
        w = '{8'h42, 2'd1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0,
              8'h42, 4'b1101};
        xfer8(w, 1'b1);
        a_cs_release = 1'b1;
        @(negedge clk);
        a_cs_release = 1'b0;
        chk("rel_csn", {28'd0, a_cs_n}, 32'hF);
        chk("rel_busy", {31'd0, a_busy}, 32'd0);
        @(negedge clk);
        chk("rel_idle", {28'd0, a_cs_n}, 32'hF);
        quiet(6);

        // Reset at the 5th sck edge of a word in flight.
        a_data_in = 8'h5A; a_cs_sel = 2'd1; a_cpol = 1'b0; a_cpha = 1'b0;
        a_div = 8'd1; a_hold = 1'b0; a_loop = 1'b1; a_start = 1'b1;
        prev = a_sck;
        n = 0;
        for (int i = 0; i < 60 && n < 5; i++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (a_sck !== prev) n++;
            prev = a_sck;
        end
        chk("rst_edge5", n, 5);
        rst_n = 1'b0;
        #1;
        chk("arst_csn", {28'd0, a_cs_n}, 32'hF);
        chk("arst_sck", {31'd0, a_sck}, 32'd0);
        chk("arst_busy", {31'd0, a_busy}, 32'd0);
        chk("arst_dout", {24'd0, a_data_out}, 32'd0);
        chk("arst_mosi", {31'd0, a_mosi}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(4);
        w = '{8'h3C, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0,
              8'h3C, 4'b1110};
        xfer8(w, 1'b0);

        // 16-bit instance: invalid select, then a mode-1 word.
        b_data_in = 16'h1234; b_cs_sel = 2'd3; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("inv_busy", {31'd0, b_busy}, 32'd0);
        chk("inv_csn", {29'd0, b_cs_n}, 32'h7);
        quiet(4);
        b_data_in = 16'hBEEF; b_cs_sel = 2'd2; b_cpol = 1'b0;
        b_cpha = 1'b1; b_div = 8'd0; b_start = 1'b1;
        t0 = cyc;
        push(1'b1, 16'hBEEF, t0 + 34);
        @(negedge clk);
        b_start = 1'b0;
        chk("w16_csn", {29'd0, b_cs_n}, 32'h3);
        chk("w16_busy", {31'd0, b_busy}, 32'd1);
        wait_nd(100);
        @(negedge clk);
        chk("w16_idle", {29'd0, b_cs_n}, 32'h7);
        chk("sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
